// File: rtl/c_arb_merge_fifo_pkg.sv
// c_pipe_pkg: shared reset polarity and width helpers for the clocked micropipeline blocks
package c_pipe_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c_arb_merge_fifo_rr_arb.sv
// c_rr_arb: round-robin grant over a request vector, searching from ptr_i+1 with wrap
module c_rr_arb
    import c_pipe_pkg::*;
#(
    parameter int NCH = 3,
    localparam int CW = clog2w(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CW-1:0]  gnt_id_o,
    output logic           gnt_vld_o
);

    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    // first requester after the pointer wins; the pointer's own channel is searched last
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 1; i <= NCH; i++) begin
            sum = {1'b0, ptr_i} + (CW + 1)'(i);
            idx = (sum >= (CW + 1)'(NCH)) ? CW'(sum - (CW + 1)'(NCH)) : CW'(sum);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/c_arb_merge_fifo.sv
// c_arb_merge_fifo: round-robin merge of NCH pulse channels into an elastic DEPTH-stage fire chain
module c_arb_merge_fifo
    import c_pipe_pkg::*;
#(
    parameter int NCH = 3,
    parameter int DEPTH = 3,
    localparam int CW = clog2w(NCH),
    localparam int CNTW = clog2w(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   i_drive,
    output logic [NCH-1:0]   o_free,
    output logic             o_driveNext,
    output logic [CW-1:0]    o_chanNext,
    input  logic             i_freeNext,
    output logic [DEPTH-1:0] o_fire,
    output logic [CNTW-1:0]  o_count,
    output logic             o_overrun
);

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] id;
    } stage_t;

    stage_t [DEPTH-1:0] stg_q, stg_d;
    logic [NCH-1:0]     pend_q, pend_d, arb_gnt, gnt_m, free_q;
    logic [CW-1:0]      ptr_q, ptr_d, gnt_id, chan_q;
    logic [DEPTH-1:0]   vac, fire_d, fire_q;
    logic [CNTW-1:0]    cnt_d, cnt_q;
    logic               gnt_vld, load0, issue, busy_q, busy_d, ovr_d, ovr_q, drv_q;

    c_rr_arb #(.NCH(NCH)) u_arb (
        .req_i    (pend_q),
        .ptr_i    (ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (gnt_id),
        .gnt_vld_o(gnt_vld)
    );

    // elastic shift: a stage vacates when its successor is empty or itself vacating
    always_comb begin
        issue            = stg_q[DEPTH-1].valid & ~busy_q;
        vac              = '0;
        vac[DEPTH-1]     = issue;
        for (int k = DEPTH - 2; k >= 0; k--)
            vac[k] = stg_q[k].valid & (~stg_q[k+1].valid | vac[k+1]);
        load0            = gnt_vld & (~stg_q[0].valid | vac[0]);
        stg_d            = stg_q;
        fire_d           = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            fire_d[k] = vac[k-1];
            stg_d[k]  = vac[k-1] ? stg_q[k-1] : (vac[k] ? stage_t'('0) : stg_q[k]);
        end
        fire_d[0]        = load0;
        stg_d[0]         = load0 ? stage_t'{valid: 1'b1, id: gnt_id} : (vac[0] ? stage_t'('0) : stg_q[0]);
    end

    // pending requests, overrun detection, pointer and outstanding-token tracking
    always_comb begin
        gnt_m  = load0 ? arb_gnt : '0;
        pend_d = (pend_q & ~gnt_m) | i_drive;
        ovr_d  = ovr_q | (|(i_drive & pend_q & ~gnt_m));
        ptr_d  = load0 ? gnt_id : ptr_q;
        busy_d = issue | (busy_q & ~i_freeNext);
    end

    // occupancy after this edge's moves
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < DEPTH; k++)
            cnt_d = cnt_d + CNTW'(stg_d[k].valid);
    end

    // state and one-cycle output pulses; reset discards everything immediately
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            stg_q  <= '0;
            pend_q <= '0;
            ptr_q  <= CW'(NCH - 1);
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
            free_q <= '0;
            fire_q <= '0;
            drv_q  <= 1'b0;
            chan_q <= '0;
            cnt_q  <= '0;
        end else begin
            stg_q  <= stg_d;
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            ovr_q  <= ovr_d;
            free_q <= gnt_m;
            fire_q <= fire_d;
            drv_q  <= issue;
            chan_q <= issue ? stg_q[DEPTH-1].id : '0;
            cnt_q  <= cnt_d;
        end
    end

    assign o_free      = free_q;
    assign o_fire      = fire_q;
    assign o_driveNext = drv_q;
    assign o_chanNext  = chan_q;
    assign o_count     = cnt_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_c_arb_merge_fifo.sv
// tb_c_arb_merge_fifo: directed checks of arbitration order, latency, backpressure and reset
module tb_c_arb_merge_fifo;

    logic       clk;
    logic       rst;
    logic [2:0] i_drive;
    logic [2:0] o_free;
    logic       o_driveNext;
    logic [1:0] o_chanNext;
    logic       i_freeNext;
    logic [2:0] o_fire;
    logic [1:0] o_count;
    logic       o_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] t3_seq [6];

    c_arb_merge_fifo #(.NCH(3), .DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_drive    (i_drive),
        .o_free     (o_free),
        .o_driveNext(o_driveNext),
        .o_chanNext (o_chanNext),
        .i_freeNext (i_freeNext),
        .o_fire     (o_fire),
        .o_count    (o_count),
        .o_overrun  (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        i_drive    = '0;
        i_freeNext = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input int exp);
        int n;
        n = 0;
        while (!o_driveNext && n < 30) begin
            step();
            n++;
        end
        check({tag, "_seen"}, o_driveNext, 1);
        check({tag, "_chan"}, o_chanNext, exp);
        i_freeNext = 1'b1;
        step();
        i_freeNext = 1'b0;
    endtask

    initial begin
        int extra;
        t3_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b010};
        rst        = 1'b0;
        i_drive    = '0;
        i_freeNext = 1'b0;
        step();
        check("rst_free", o_free, 0);
        check("rst_fire", o_fire, 0);
        check("rst_drv", o_driveNext, 0);
        check("rst_cnt", o_count, 0);
        check("rst_ovr", o_overrun, 0);
        do_reset();

        // single token on channel 1: latency through the chain
        i_drive = 3'b010;
        step();
        i_drive = '0;
        step();
        check("t1_free", o_free, 3'b010);
        check("t1_fire0", o_fire, 3'b001);
        check("t1_cnt", o_count, 1);
        step();
        check("t1_fire1", o_fire, 3'b010);
        step();
        check("t1_fire2", o_fire, 3'b100);
        check("t1_drv4", o_driveNext, 0);
        step();
        check("t1_drv5", o_driveNext, 1);
        check("t1_chan5", o_chanNext, 1);
        check("t1_cnt5", o_count, 0);
        i_freeNext = 1'b1;
        step();
        i_freeNext = 1'b0;
        check("t1_drv6", o_driveNext, 0);

        // all channels at once, plus channel 0 re-driven in its grant cycle
        do_reset();
        i_drive = 3'b111;
        step();
        i_drive = 3'b001;
        step();
        i_drive = '0;
        check("t2_free_c2", o_free, 3'b001);
        step();
        check("t2_free_c3", o_free, 3'b010);
        step();
        check("t2_free_c4", o_free, 3'b100);
        step();
        check("t2_free_c5", o_free, 3'b001);
        drain("t2_a", 0);
        drain("t2_b", 1);
        drain("t2_c", 2);
        drain("t2_d", 0);
        check("t2_ovr", o_overrun, 0);

        // no downstream return: fill, overrun on the sixth pulse, then drain in order
        do_reset();
        for (int c = 0; c < 12; c++) begin
            i_drive = (c % 2 == 0) ? t3_seq[c/2] : 3'b000;
            if (c == 5) begin
                check("t3_drv_a", o_driveNext, 1);
                check("t3_chan_a", o_chanNext, 0);
            end
            if (c == 10) begin
                check("t3_cnt_full", o_count, 3);
                check("t3_ovr_c10", o_overrun, 0);
            end
            if (c == 11) begin
                check("t3_ovr_c11", o_overrun, 1);
                check("t3_fire_stall", o_fire, 0);
                check("t3_free_stall", o_free, 0);
            end
            step();
        end
        i_freeNext = 1'b1;
        step();
        i_freeNext = 1'b0;
        drain("t3_b", 1);
        drain("t3_c", 2);
        drain("t3_d", 0);
        drain("t3_e", 1);
        extra = 0;
        repeat (8) begin
            step();
            if (o_driveNext) extra++;
        end
        check("t3_extra", extra, 0);
        check("t3_cnt_empty", o_count, 0);
        check("t3_ovr_sticky", o_overrun, 1);

        // channels 0 and 2 only: strict alternation from the reset pointer
        do_reset();
        for (int c = 0; c < 7; c++) begin
            i_drive    = (c == 0 || c == 3) ? 3'b101 : 3'b000;
            i_freeNext = (c == 5);
            if (c == 2) check("t4_free_c2", o_free, 3'b001);
            if (c == 3) check("t4_free_c3", o_free, 3'b100);
            if (c == 4) check("t4_free_c4", o_free, 3'b000);
            if (c == 5) begin
                check("t4_free_c5", o_free, 3'b001);
                check("t4_drv_c5", o_driveNext, 1);
                check("t4_chan_c5", o_chanNext, 0);
            end
            if (c == 6) check("t4_free_c6", o_free, 3'b100);
            step();
        end
        i_freeNext = 1'b0;
        drain("t4_b", 2);
        drain("t4_c", 0);
        drain("t4_d", 2);

        // free while idle is ignored; free coincident with arrival at the last stage
        do_reset();
        i_freeNext = 1'b1;
        step();
        i_freeNext = 1'b0;
        step();
        check("t5_idle_drv", o_driveNext, 0);
        check("t5_idle_cnt", o_count, 0);
        for (int c = 0; c < 9; c++) begin
            i_drive    = (c == 0) ? 3'b001 : (c == 2) ? 3'b010 : 3'b000;
            i_freeNext = (c == 3 || c == 6);
            if (c == 5) begin
                check("t5_drv_c5", o_driveNext, 1);
                check("t5_chan_c5", o_chanNext, 0);
            end
            if (c == 6) check("t5_cnt_c6", o_count, 1);
            if (c == 7) check("t5_drv_c7", o_driveNext, 0);
            if (c == 8) begin
                check("t5_drv_c8", o_driveNext, 1);
                check("t5_chan_c8", o_chanNext, 1);
            end
            step();
        end
        i_freeNext = 1'b1;
        step();
        i_freeNext = 1'b0;

        // asynchronous reset with a full pipeline and a token outstanding
        do_reset();
        for (int c = 0; c < 11; c++) begin
            i_drive = (c == 0) ? 3'b111 : (c == 2) ? 3'b010 : 3'b000;
            if (c == 10) check("t6_cnt_pre", o_count, 3);
            if (c < 10) step();
        end
        #3;
        rst = 1'b0;
        #1;
        check("t6_cnt_rst", o_count, 0);
        check("t6_drv_rst", o_driveNext, 0);
        check("t6_free_rst", o_free, 0);
        check("t6_fire_rst", o_fire, 0);
        check("t6_ovr_rst", o_overrun, 0);
        step();
        step();
        rst     = 1'b1;
        i_drive = 3'b111;
        step();
        i_drive = '0;
        check("t6_rel_free", o_free, 0);
        check("t6_rel_drv", o_driveNext, 0);
        step();
        check("t6_free_c2", o_free, 3'b001);
        check("t6_fire_c2", o_fire, 3'b001);
        step();
        step();
        step();
        check("t6_drv_c5", o_driveNext, 1);
        check("t6_chan_c5", o_chanNext, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
